// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit multicycle RISC core
module multicycle_ctrl #(
  parameter int OPW  = 4,
  parameter int ST_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic [1:0]      pc_src_sel,
  output logic [1:0]      alu_b_sel,
  output logic [1:0]      wb_sel,
  output logic [1:0]      alu_op,
  output logic            reg_dst_r7,
  output logic            pc_we,
  output logic            ir_we,
  output logic            reg_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);
  typedef enum logic [ST_W-1:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(3);
  localparam logic [OPW-1:0] OP_LW   = OPW'(4);
  localparam logic [OPW-1:0] OP_SW   = OPW'(5);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(8);
  localparam logic [OPW-1:0] OP_CALL = OPW'(9);
  localparam logic [OPW-1:0] OP_RET  = OPW'(10);
  state_t st, nxt;
  logic [OPW-1:0] op_q;
  logic is_alu, is_imm, is_br, is_call, is_ret, is_jmp, is_lw;
  assign state   = st;
  assign is_alu  = op_q < OP_ADDI;
  assign is_imm  = op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW;
  assign is_br   = op_q == OP_BEQ || op_q == OP_BNE;
  assign is_jmp  = op_q == OP_JMP;
  assign is_call = op_q == OP_CALL;
  assign is_ret  = op_q == OP_RET;
  assign is_lw   = op_q == OP_LW;
  // IR is written on the FETCH->DECODE edge, so the opcode is captured while in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      op_q <= '0;
    end else begin
      st <= nxt;
      if (st == S_DECODE) op_q <= opcode;
    end
  end
  always_comb begin
    nxt        = S_IDLE;
    pc_src_sel = 2'b00;
    alu_b_sel  = 2'b00;
    wb_sel     = 2'b00;
    alu_op     = 2'b00;
    reg_dst_r7 = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    illegal_op = 1'b0;
    case (st)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_we  = mem_ready;
        pc_we  = mem_ready;
        nxt    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal_op = opcode > OP_RET;
        nxt        = illegal_op ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        alu_b_sel  = is_imm ? 2'b01 : 2'b00;
        alu_op     = (op_q == OP_SUB || is_br) ? 2'b01 : op_q == OP_AND ? 2'b10 : 2'b00;
        pc_src_sel = is_br ? 2'b01 : (is_jmp || is_call) ? 2'b10 : is_ret ? 2'b11 : 2'b00;
        pc_we      = is_br ? (alu_zero ^ (op_q == OP_BNE)) : (is_jmp || is_call || is_ret);
        reg_we     = is_call;
        wb_sel     = is_call ? 2'b10 : 2'b00;
        reg_dst_r7 = is_call;
        nxt        = (is_alu || op_q == OP_ADDI) ? S_WB : (is_lw || op_q == OP_SW) ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = !is_lw;
        nxt    = !mem_ready ? S_MEM : is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = is_lw ? 2'b01 : 2'b00;
        nxt    = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction expected-output timelines checked cycle by cycle against the FSM
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] opcode = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;
  logic [1:0] pc_src_sel, alu_b_sel, wb_sel, alu_op;
  logic reg_dst_r7, pc_we, ir_we, reg_we, mem_rd, mem_wr, illegal_op;
  logic [2:0] state, idle_code;
  logic [14:0] got;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic rdy; logic ex; logic z; logic dec; logic [3:0] op; logic [14:0] exp; int ph;
  } step_t;
  step_t plan[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_src_sel(pc_src_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .alu_op(alu_op),
    .reg_dst_r7(reg_dst_r7), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;
  assign got = {pc_src_sel, alu_b_sel, wb_sel, alu_op, reg_dst_r7, pc_we, ir_we, reg_we, mem_rd, mem_wr, illegal_op};

  function automatic logic [14:0] o(logic [1:0] pc, logic [1:0] b, logic [1:0] wb, logic [1:0] aop,
                                    logic r7, logic pcwe, logic irwe, logic regwe, logic rd, logic wr, logic ill);
    return {pc, b, wb, aop, r7, pcwe, irwe, regwe, rd, wr, ill};
  endfunction

  task automatic add(logic rdy, logic ex, logic z, logic dec, logic [3:0] op, logic [14:0] exp, int ph);
    step_t e;
    e.rdy = rdy; e.ex = ex; e.z = z; e.dec = dec; e.op = op; e.exp = exp; e.ph = ph;
    plan.push_back(e);
  endtask

  // Expected timeline of one instruction, written straight from the opcode table
  task automatic build(logic [3:0] op, logic z, int fw, int mw);
    logic [14:0] ex;
    for (int i = 0; i < fw; i++) add(1'b0, 1'b0, 1'b0, 1'b0, op, o(0,0,0,0,0,0,0,0,1,0,0), 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, op, o(0,0,0,0,0,1,1,0,1,0,0), 0);
    add(1'($urandom), 1'b0, 1'b0, 1'b1, op, o(0,0,0,0,0,0,0,0,0,0,op > 4'hA), 1);
    if (op > 4'hA) return;
    case (op)
      4'h0: ex = o(0,0,0,0,0,0,0,0,0,0,0);
      4'h1: ex = o(0,0,0,1,0,0,0,0,0,0,0);
      4'h2: ex = o(0,0,0,2,0,0,0,0,0,0,0);
      4'h3, 4'h4, 4'h5: ex = o(0,1,0,0,0,0,0,0,0,0,0);
      4'h6: ex = o(1,0,0,1,0,z,0,0,0,0,0);
      4'h7: ex = o(1,0,0,1,0,!z,0,0,0,0,0);
      4'h8: ex = o(2,0,0,0,0,1,0,0,0,0,0);
      4'h9: ex = o(2,0,2,0,1,1,0,1,0,0,0);
      default: ex = o(3,0,0,0,0,1,0,0,0,0,0);
    endcase
    add(1'($urandom), 1'b1, z, 1'b0, op, ex, 2);
    if (op == 4'h4 || op == 4'h5) begin
      for (int i = 0; i < mw; i++) add(1'b0, 1'b0, 1'b0, 1'b0, op, o(0,0,0,0,0,0,0,0,op == 4'h4,op == 4'h5,0), 3);
      add(1'b1, 1'b0, 1'b0, 1'b0, op, o(0,0,0,0,0,0,0,0,op == 4'h4,op == 4'h5,0), 3);
    end
    if (op <= 4'h4) add(1'($urandom), 1'b0, 1'b0, 1'b0, op, o(0,0,op == 4'h4 ? 2'b01 : 2'b00,0,0,0,0,1,0,0,0), 4);
  endtask

  task automatic chk(string tag, logic [14:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Opcode is only meaningful in DECODE; elsewhere it is scrambled to prove the latch holds
  task automatic step(step_t e);
    @(negedge clk);
    mem_ready = e.rdy;
    alu_zero  = e.ex ? e.z : 1'($urandom);
    opcode    = e.dec ? e.op : 4'($urandom);
    #1;
    n_cmp++;
    assert (got === e.exp) else begin
      n_err++;
      $error("FAIL cycle op=%h ph=%0d got=%h exp=%h", e.op, e.ph, got, e.exp);
    end
  endtask

  task automatic drain();
    while (plan.size() > 0) step(plan.pop_front());
  endtask

  initial begin
    #1;
    chk("reset_outputs", '0);
    idle_code = state;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", '0);
    build(4'h0, 1'b0, 0, 0);
    build(4'h4, 1'b0, 0, 3);
    build(4'h6, 1'b1, 0, 0);
    build(4'h6, 1'b0, 1, 0);
    build(4'h7, 1'b1, 0, 0);
    build(4'h7, 1'b0, 0, 0);
    build(4'h9, 1'b0, 0, 0);
    build(4'hA, 1'b0, 0, 0);
    build(4'hC, 1'b0, 0, 0);
    build(4'h5, 1'b0, 2, 2);
    build(4'h3, 1'b0, 0, 0);
    build(4'h8, 1'b0, 0, 0);
    build(4'h1, 1'b0, 0, 0);
    build(4'h2, 1'b0, 0, 0);
    drain();
    for (int k = 0; k < 80; k++) build(4'($urandom), 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    drain();
    build(4'h4, 1'b0, 0, 3);
    for (int k = 0; k < 4; k++) step(plan.pop_front());
    plan.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_stall", '0);
    n_cmp++;
    assert (state === idle_code) else begin
      n_err++;
      $error("FAIL reset_state got=%h exp=%h", state, idle_code);
    end
    @(negedge clk);
    #1;
    chk("reset_held", '0);
    rst_n = 1'b1;
    #1;
    chk("idle_after_stall_reset", '0);
    build(4'h4, 1'b0, 0, 1);
    build(4'hF, 1'b0, 0, 0);
    build(4'h0, 1'b0, 0, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
